// File: rtl/button_bank.sv
// Bank of independent push-button conditioners: two-flop synchroniser, stability
// debounce, registered held level, press/release pulses and optional auto-repeat.
module button_bank #(
    parameter int N_BUTTONS       = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] repeat_pulse,
    output logic                 any_pressed
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [N_BUTTONS-1:0] REL_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

    logic [N_BUTTONS-1:0] sync0, sync1, act;
    logic [CW-1:0]        deb_q  [N_BUTTONS];
    logic [CW-1:0]        deb_d  [N_BUTTONS];
    logic [HW-1:0]        hold_q [N_BUTTONS];
    logic [HW-1:0]        hold_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] phase_q, phase_d;
    logic [N_BUTTONS-1:0] pressed_d, press_d, release_d, repeat_d;
    logic                 toggle;

    assign act = sync1 ^ REL_LEVEL;

    always_comb begin
        deb_d     = deb_q;
        hold_d    = hold_q;
        phase_d   = phase_q;
        pressed_d = pressed;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        toggle    = 1'b0;
        for (int unsigned i = 0; i < unsigned'(N_BUTTONS); i++) begin
            toggle = 1'b0;
            if (act[i] == pressed[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_LAST) begin
                toggle       = 1'b1;
                deb_d[i]     = '0;
                pressed_d[i] = act[i];
                press_d[i]   = act[i];
                release_d[i] = ~act[i];
            end else begin
                deb_d[i] = deb_q[i] + CW'(1);
            end

            // phase_q selects between the initial delay and the repeat period;
            // an accepted release in this cycle suppresses any repeat.
            if (REPEAT_EN && pressed[i] && !toggle) begin
                if (hold_q[i] == (phase_q[i] ? PER_LAST : DLY_LAST)) begin
                    repeat_d[i] = 1'b1;
                    hold_d[i]   = '0;
                    phase_d[i]  = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end else begin
                hold_d[i]  = '0;
                phase_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0         <= REL_LEVEL;
            sync1         <= REL_LEVEL;
            deb_q         <= '{default: '0};
            hold_q        <= '{default: '0};
            phase_q       <= '0;
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            any_pressed   <= 1'b0;
        end else begin
            sync0         <= buttons_raw;
            sync1         <= sync0;
            deb_q         <= deb_d;
            hold_q        <= hold_d;
            phase_q       <= phase_d;
            pressed       <= pressed_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            any_pressed   <= |pressed_d;
        end
    end

endmodule
